// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns (same table the
// hex-to-7-segment encoder uses), scan FSM state type and anode helper.
package seg7_pkg;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Stability counter width; covers the full 1..255 settle range
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } scanState_e;

  // True when exactly one bit of the (active-low) anode vector is low.
  // Callers pad unused upper bits with ones so they never count.
  function automatic logic isOneHotLow(input logic [31:0] anN);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 32; i++) begin
      if (!anN[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-monitor bus: the scanned display lines going in and the recovered
// per-digit values and strobes coming out.
interface seg7_scan_decoder_if #(
  parameter int DIGITS = 4,
  parameter int WL     = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0]    an;
  logic [6:0]           seg;
  logic [DIGITS*WL-1:0] digits;
  logic [DIGITS-1:0]    valid;
  logic                 upd;
  logic [IW-1:0]        upd_idx;
  logic                 err;
  logic                 frame_done;

  // Side that drives the display lines and watches the recovered values
  modport master (
    output an, seg,
    input  digits, valid, upd, upd_idx, err, frame_done
  );

  // Decoder side
  modport slave (
    input  an, seg,
    output digits, valid, upd, upd_idx, err, frame_done
  );

endinterface

// File: rtl/seg7_to_hex.sv
// Inverse of the hex-to-7-segment encoder: maps an active-low segment
// pattern back to its hex value, flagging blank and unrecognised patterns.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       hit_o,
  output logic       blank_o
);

  // Table lookup; anything not a glyph or blank is reported as a miss
  always_comb begin
    value_o = 4'h0;
    hit_o   = 1'b1;
    blank_o = 1'b0;
    case (seg_i)
      SEG_0:     value_o = 4'h0;
      SEG_1:     value_o = 4'h1;
      SEG_2:     value_o = 4'h2;
      SEG_3:     value_o = 4'h3;
      SEG_4:     value_o = 4'h4;
      SEG_5:     value_o = 4'h5;
      SEG_6:     value_o = 4'h6;
      SEG_7:     value_o = 4'h7;
      SEG_8:     value_o = 4'h8;
      SEG_9:     value_o = 4'h9;
      SEG_A:     value_o = 4'hA;
      SEG_B:     value_o = 4'hB;
      SEG_C:     value_o = 4'hC;
      SEG_D:     value_o = 4'hD;
      SEG_E:     value_o = 4'hE;
      SEG_F:     value_o = 4'hF;
      SEG_BLANK: begin
        hit_o   = 1'b0;
        blank_o = 1'b1;
      end
      default:   hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex digits shown on a multiplexed active-low 7-segment
// display. Each anode/segment sample must stay unchanged for STABLE_CYCLES
// samples before it is captured, which filters scan-transition ghosting.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int WL            = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int              IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // Sample registers. The *_d values are the sample entering *_q on this
  // edge, so all decisions below compare "this sample" against "previous
  // sample" and a capture can land on the very edge the sample is stored.
  logic [DIGITS-1:0] an_d, an_q;
  logic [6:0]        seg_d, seg_q;

  scanState_e        state_d, state_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic [CNT_W:0]    countInc;
  logic              capture;

  logic [31:0]       anWide;
  logic              anOneHot;
  logic              sampleChanged;
  logic [IW-1:0]     selIdx;

  logic [3:0]        hexValue;
  logic              hexHit;
  logic              hexBlank;

  logic [DIGITS*WL-1:0] digits_d, digits_q;
  logic [DIGITS-1:0]    valid_d, valid_q;
  logic [DIGITS-1:0]    seen_d, seen_q;
  logic [DIGITS-1:0]    seenNext;
  logic                 upd_d, upd_q;
  logic [IW-1:0]        updIdx_d, updIdx_q;
  logic                 err_d, err_q;
  logic                 frameDone_d, frameDone_q;

  assign an_d  = bus.an;
  assign seg_d = bus.seg;

  seg7_to_hex u_decode (
    .seg_i   (seg_d),
    .value_o (hexValue),
    .hit_o   (hexHit),
    .blank_o (hexBlank)
  );

  // Register the raw display lines; idle display (all off) after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  // Classify the incoming sample: which digit is lit, and did anything move
  always_comb begin
    anWide                = '1;
    anWide[DIGITS-1:0]    = an_d;
    anOneHot              = isOneHotLow(anWide);
    sampleChanged         = (an_d != an_q) || (seg_d != seg_q);
    selIdx                = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_d[i]) selIdx = IW'(i);
    end
  end

  // Scan FSM state and stability counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: any change restarts settling; a run of identical one-hot
  // samples reaching the threshold captures once and then parks in HELD
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    capture  = 1'b0;
    countInc = {1'b0, count_q} + 1'b1;
    if (sampleChanged) begin
      if (anOneHot) begin
        count_d = CNT_W'(1);
        if (CNT_MAX == CNT_W'(1)) begin
          state_d = ST_HELD;
          capture = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end else begin
        state_d = ST_WAIT;
        count_d = '0;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          count_d = '0;
        end
        ST_SETTLE: begin
          if (countInc >= {1'b0, CNT_MAX}) begin
            count_d = CNT_MAX;
            state_d = ST_HELD;
            capture = 1'b1;
          end else begin
            count_d = countInc[CNT_W-1:0];
          end
        end
        ST_HELD: begin
          count_d = count_q;
        end
        default: begin
          state_d = ST_WAIT;
          count_d = '0;
        end
      endcase
    end
  end

  // Capture datapath: update the selected digit, raise the strobes and
  // track which digits have been seen since the last frame strobe
  always_comb begin
    digits_d    = digits_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    updIdx_d    = updIdx_q;
    upd_d       = 1'b0;
    err_d       = 1'b0;
    frameDone_d = 1'b0;
    seenNext    = seen_q | (DIGITS'(1) << selIdx);
    if (capture) begin
      upd_d    = 1'b1;
      updIdx_d = selIdx;
      if (hexHit) begin
        digits_d[selIdx*WL +: WL] = WL'(hexValue);
        valid_d[selIdx]           = 1'b1;
      end else begin
        valid_d[selIdx] = 1'b0;
        err_d           = !hexBlank;
      end
      if (seenNext == {DIGITS{1'b1}}) begin
        frameDone_d = 1'b1;
        seen_d      = '0;
      end else begin
        seen_d = seenNext;
      end
    end
  end

  // Output register file and strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q    <= '0;
      valid_q     <= '0;
      seen_q      <= '0;
      upd_q       <= 1'b0;
      updIdx_q    <= '0;
      err_q       <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      upd_q       <= upd_d;
      updIdx_q    <= updIdx_d;
      err_q       <= err_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.valid      = valid_q;
  assign bus.upd        = upd_q;
  assign bus.upd_idx    = updIdx_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scan sequences push the
// expected capture into a queue, a negedge monitor pops on every upd.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  localparam int KIND_GLYPH = 0;
  localparam int KIND_BLANK = 1;
  localparam int KIND_BAD   = 2;

  typedef struct {
    int          idx;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        err;
    logic        frame;
  } expect_t;

  logic clk = 1'b0;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;

  expect_t     sbQueue[$];
  logic [15:0] modelDigits;
  logic [3:0]  modelValid;

  seg7_scan_decoder_if #(.DIGITS(4), .WL(4)) bus ();

  seg7_scan_decoder #(
    .DIGITS        (4),
    .WL            (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " digits"},     32'(bus.digits),     32'h0);
    checkOutput({tag, " valid"},      32'(bus.valid),      32'h0);
    checkOutput({tag, " upd"},        32'(bus.upd),        32'h0);
    checkOutput({tag, " upd_idx"},    32'(bus.upd_idx),    32'h0);
    checkOutput({tag, " err"},        32'(bus.err),        32'h0);
    checkOutput({tag, " frame_done"}, 32'(bus.frame_done), 32'h0);
  endtask

  task automatic expectCapture(input int idx, input int kind, input logic [3:0] value, input logic frame);
    expect_t e;
    if (kind == KIND_GLYPH) begin
      modelDigits[idx*4 +: 4] = value;
      modelValid[idx]         = 1'b1;
    end else begin
      modelValid[idx] = 1'b0;
    end
    e.idx    = idx;
    e.digits = modelDigits;
    e.valid  = modelValid;
    e.err    = (kind == KIND_BAD);
    e.frame  = frame;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] anV, input logic [6:0] segV, input int cycles);
    bus.an  = anV;
    bus.seg = segV;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.upd) begin
        if (sbQueue.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected upd: got upd_idx %0d, expected no capture", bus.upd_idx);
        end else begin
          expect_t e;
          e = sbQueue.pop_front();
          checkOutput("upd_idx",    32'(bus.upd_idx),    32'(e.idx));
          checkOutput("digits",     32'(bus.digits),     32'(e.digits));
          checkOutput("valid",      32'(bus.valid),      32'(e.valid));
          checkOutput("err",        32'(bus.err),        32'(e.err));
          checkOutput("frame_done", 32'(bus.frame_done), 32'(e.frame));
        end
      end else if (bus.err || bus.frame_done) begin
        checkOutput("stray err/frame_done", 32'({bus.err, bus.frame_done}), 32'h0);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.an      = 4'b1111;
    bus.seg     = SEG_BLANK;
    modelDigits = '0;
    modelValid  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("power-up");
    rst = 1'b0;

    // First capture, then a partial settle cut short by an async reset
    expectCapture(0, KIND_GLYPH, 4'h3, 1'b0);
    applyStimulus(4'b1110, SEG_3, 4);
    applyStimulus(4'b1101, SEG_5, 2);
    #3 rst = 1'b1;
    #1 checkReset("async reset");
    modelDigits = '0;
    modelValid  = '0;
    bus.an      = 4'b1111;
    bus.seg     = SEG_BLANK;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Minimum hold captures digit 0
    expectCapture(0, KIND_GLYPH, 4'h3, 1'b0);
    applyStimulus(4'b1110, SEG_3, 4);
    checkOutput("digit0 after reset", 32'(bus.digits[3:0]), 32'h3);
    checkOutput("valid after reset",  32'(bus.valid),       32'h1);

    // Full frame 1,2,b,F
    expectCapture(0, KIND_GLYPH, 4'h1, 1'b0);
    applyStimulus(4'b1110, SEG_1, 8);
    expectCapture(1, KIND_GLYPH, 4'h2, 1'b0);
    applyStimulus(4'b1101, SEG_2, 8);
    expectCapture(2, KIND_GLYPH, 4'hB, 1'b0);
    applyStimulus(4'b1011, SEG_B, 8);
    expectCapture(3, KIND_GLYPH, 4'hF, 1'b1);
    applyStimulus(4'b0111, SEG_F, 8);
    checkOutput("frame digits", 32'(bus.digits), 32'h0000FB21);
    checkOutput("frame valid",  32'(bus.valid),  32'hF);

    // Ghost 8 for three samples, then a real digit
    applyStimulus(4'b1110, SEG_8, 3);
    expectCapture(1, KIND_GLYPH, 4'h2, 1'b0);
    applyStimulus(4'b1101, SEG_2, 8);
    checkOutput("ghost digits", 32'(bus.digits), 32'h0000FB21);
    applyStimulus(4'b0111, SEG_8, 3);
    applyStimulus(4'b1111, SEG_BLANK, 2);

    // Bad pattern, then blank, on digit 2
    expectCapture(2, KIND_BAD, 4'h0, 1'b0);
    applyStimulus(4'b1011, 7'b1010101, 8);
    checkOutput("bad keeps digit2", 32'(bus.digits[11:8]), 32'hB);
    checkOutput("bad clears valid2", 32'(bus.valid[2]),    32'h0);
    expectCapture(2, KIND_BLANK, 4'h0, 1'b0);
    applyStimulus(4'b1011, SEG_BLANK, 8);

    // Illegal anode patterns never leave WAIT
    applyStimulus(4'b1100, SEG_8, 20);
    checkOutput("two anodes low state", 32'(dut.state_q), 32'(ST_WAIT));
    applyStimulus(4'b1111, SEG_8, 20);
    checkOutput("no anode state", 32'(dut.state_q), 32'(ST_WAIT));

    // Re-capture on digit 0 without an anode change
    expectCapture(0, KIND_GLYPH, 4'h0, 1'b0);
    applyStimulus(4'b1110, SEG_0, 8);
    expectCapture(0, KIND_GLYPH, 4'h9, 1'b0);
    applyStimulus(4'b1110, SEG_9, 8);
    checkOutput("recapture digits", 32'(bus.digits), 32'h0000FB29);

    // Last unseen digit completes the frame
    expectCapture(3, KIND_GLYPH, 4'h7, 1'b1);
    applyStimulus(4'b0111, SEG_7, 8);
    applyStimulus(4'b1111, SEG_BLANK, 4);
    checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Recovers hex digit values from a time-multiplexed, active-low 7-segment display bus (anodes plus shared segment lines). It is the inverse of the hex-to-7-segment encoder and sits on the display-monitor path, where it lets self-check logic and the test harness read back what the display is actually showing. It filters ghosting on scan transitions with a per-digit stability counter. It reports per-digit values, validity, decode errors and a frame-complete strobe.

## Interface
- `DIGITS`, 4: number of multiplexed digits (anode width).
- `WL`, 4: width of each recovered value.
- `STABLE_CYCLES`, 4: consecutive identical samples required before capture; range 1..255.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `an` in DIGITS: anode enables, active-low; exactly one low selects a digit.
- `seg` in 7: segment lines, active-low; bit 6 = a … bit 0 = g.
- `digits` out DIGITS*WL: recovered values; digit i at [i*WL +: WL].
- `valid` out DIGITS: digit i holds a recognised hex glyph.
- `upd` out 1: one-cycle pulse on each capture.
- `upd_idx` out clog2(DIGITS): digit index of the current `upd`.
- `err` out 1: one-cycle pulse when a captured pattern is neither a glyph nor blank.
- `frame_done` out 1: one-cycle pulse when every digit has been captured since the last pulse.

## Operation
- Input stage: `an` and `seg` are registered into `an_q` and `seg_q` every cycle. The logic below operates on `an_q` and `seg_q`.
- Decode table (`seg` to value), 16 entries:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→b
  - 0110001→C, 1000010→d, 0110000→E, 0111000→F
  - 1111111 is BLANK. Any other pattern is BAD.
- FSM states:
  - WAIT: `an_q` is not one-hot-low (all high, or more than one low). Counter held at 0.
  - SETTLE: `an_q` is one-hot-low. Counter increments each cycle in which `an_q`/`seg_q` equal the previous sample.
  - HELD: capture done; wait for a change.
- FSM transitions:
  - Any change in `an_q` or `seg_q` goes to SETTLE with count 1 if the new `an_q` is one-hot-low, otherwise to WAIT. This applies from every state.
  - SETTLE goes to HELD when count reaches `STABLE_CYCLES`. The capture happens on that edge.
  - HELD never re-captures while the inputs stay unchanged.
- Capture for selected digit i:
  - Glyph: `digits[i]` is loaded, `valid[i]`=1.
  - BLANK: `digits[i]` is unchanged, `valid[i]`=0, no `err`.
  - BAD: `digits[i]` is unchanged, `valid[i]`=0, `err`=1.
  - All three outcomes pulse `upd` with `upd_idx`=i and set `seen[i]`.
- Frame tracking:
  - When `seen` with the new bit would become all-ones, `frame_done` pulses in the same cycle as that `upd`, and `seen` clears to 0.
  - Re-capturing an already-seen digit does not affect `frame_done`.
- Reset values:
  - `digits`=0, `valid`=0, `upd`=0, `upd_idx`=0, `err`=0, `frame_done`=0.
  - State WAIT, count 0, `seen`=0, `an_q`=all-ones, `seg_q`=all-ones.
  - Reset asserted mid-settle discards the partial count. No pulse is emitted.
- Counter saturates at `STABLE_CYCLES`; there is no wrap.

## Timing
- Suppose `an`/`seg` present a new stable value V before rising edge e0 and hold it.
  - `an_q`/`seg_q` take V at e0.
  - Capture occurs at edge e0+`STABLE_CYCLES`-1.
  - `upd`/`err`/`frame_done` are high for exactly the following cycle; `digits`/`valid` are updated in that same cycle.
  - Total latency from the input change to `upd`: `STABLE_CYCLES` edges.
- A value held for `STABLE_CYCLES`-1 edges and then changed produces no capture.
- With `STABLE_CYCLES`=1, every distinct one-hot sample captures on the edge it is registered.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- `seg7_pkg`:
  - `SEG_0`…`SEG_F` and `SEG_BLANK` 7-bit constants, shared with the encoder.
  - FSM state enum (WAIT, SETTLE, HELD).
  - Helper function: one-hot-low check.
- Sub-module `seg7_to_hex`: combinational; `seg`[6:0] in; `value`[3:0], `hit`, `blank` out. Instantiated once on `seg_q`.
- Top level: sample registers, FSM, counter, digit/valid register file, `seen` mask.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately. After release, hold `an`=1110, `seg`=0000110 for 4 cycles → `upd` with `upd_idx`=0, `digits`[3:0]=3, `valid`=0001.
- **Full frame:** scan 1,2,b,F on digits 0..3, 8 cycles each → four `upd` pulses, `digits`=16'hFB21, `valid`=1111, `frame_done` coincident with the fourth `upd`.
- **Ghosting:** insert a 3-cycle glitch pattern 0000000 between digits with `STABLE_CYCLES`=4 → no capture of 8. Digit values unchanged.
- **Bad pattern and blank:**
  - `seg`=1010101 held on digit 2 → `err` pulse, `valid[2]`=0, `digits[2]` retains its previous value.
  - `seg`=1111111 → `valid[2]`=0, no `err`.
- **Illegal anodes:** `an`=1100 or 1111 held 20 cycles → no `upd`. State stays WAIT.
- **Re-capture:** digit 0 held, then `seg` changes 0→9 without an anode change → a second `upd` for digit 0 with value 9. `frame_done` is not pulsed.
